// File: rtl/rpspmc_readback_pkg.sv
// Shared types and default constants for the PS readback snapshot path.
package rpspmc_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } rb_state_e;

    localparam int unsigned DEF_BASE_ADDR    = 100001;
    localparam int unsigned DEF_ADDR_UPTIME  = 101900;
    localparam int unsigned DEF_ADDR_VERSION = 199997;
    localparam int unsigned DEF_ADDR_STATE   = 199999;

    localparam logic [31:0] DEF_VERSION_A = 32'hEC010100;
    localparam logic [31:0] DEF_VERSION_B = 32'h20250601;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SEQ_W  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned UP_W   = 32;

endpackage

// File: rtl/readback_snapshot_mux_if.sv
// PS-facing readback bus: selector from the PS, snapshot words and uptime back.
interface readback_snapshot_mux_if
    import rpspmc_readback_pkg::*;
#(
    parameter int unsigned DW = 32
);
    logic [ADDR_W-1:0] config_addr;
    logic [DW-1:0]     gpio_dataA;
    logic [DW-1:0]     gpio_dataB;
    logic              rb_valid;
    logic [SEQ_W-1:0]  rb_seq;
    logic [UP_W-1:0]   clock_sec;
    logic [UP_W-1:0]   clock_tics;

    modport master (
        output config_addr,
        input  gpio_dataA, gpio_dataB, rb_valid, rb_seq, clock_sec, clock_tics
    );

    modport slave (
        input  config_addr,
        output gpio_dataA, gpio_dataB, rb_valid, rb_seq, clock_sec, clock_tics
    );
endinterface

// File: rtl/rpspmc_uptime_counter.sv
// Free-running uptime: seconds counter plus down-counting sub-second tics.
module rpspmc_uptime_counter
    import rpspmc_readback_pkg::*;
#(
    parameter int unsigned CLK_HZ = 125000000
)(
    input  logic            aclk,
    input  logic            aresetn,
    output logic [UP_W-1:0] clock_sec,
    output logic [UP_W-1:0] clock_tics
);
    localparam logic [UP_W-1:0] TICS_MAX = UP_W'(CLK_HZ - 1);

    logic [UP_W-1:0] r_sec;
    logic [UP_W-1:0] r_tics;

    // Reload on the zero tic and roll the seconds (wraps naturally at 2^32).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sec  <= '0;
            r_tics <= TICS_MAX;
        end else if (r_tics == '0) begin
            r_sec  <= r_sec + UP_W'(1);
            r_tics <= TICS_MAX;
        end else begin
            r_tics <= r_tics - UP_W'(1);
        end
    end

    assign clock_sec  = r_sec;
    assign clock_tics = r_tics;

endmodule

// File: rtl/readback_snapshot_mux.sv
// Address-selected readback mux that captures a coherent A/B word pair once
// config_addr has been stable long enough, and holds it until the next change.
module readback_snapshot_mux
    import rpspmc_readback_pkg::*;
#(
    parameter int unsigned N_CH         = 16,
    parameter int unsigned DW           = 32,
    parameter int unsigned BASE_ADDR    = DEF_BASE_ADDR,
    parameter int unsigned ADDR_UPTIME  = DEF_ADDR_UPTIME,
    parameter int unsigned ADDR_VERSION = DEF_ADDR_VERSION,
    parameter int unsigned ADDR_STATE   = DEF_ADDR_STATE,
    parameter int unsigned CLK_HZ       = 125000000,
    parameter int unsigned SETTLE_CYC   = 2,
    parameter logic [31:0] VERSION_A    = DEF_VERSION_A,
    parameter logic [31:0] VERSION_B    = DEF_VERSION_B
)(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [ADDR_W-1:0]  config_addr,
    input  logic [N_CH*DW-1:0] ch_a,
    input  logic [N_CH*DW-1:0] ch_b,
    output logic [DW-1:0]      gpio_dataA,
    output logic [DW-1:0]      gpio_dataB,
    output logic               rb_valid,
    output logic [SEQ_W-1:0]   rb_seq,
    output logic [UP_W-1:0]    clock_sec,
    output logic [UP_W-1:0]    clock_tics
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    rb_state_e         r_state;
    rb_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_prev_addr;
    logic [DW-1:0]     r_data_a;
    logic [DW-1:0]     r_data_b;
    logic [DW-1:0]     w_data_a_nxt;
    logic [DW-1:0]     w_data_b_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [SEQ_W-1:0]  r_seq;
    logic [SEQ_W-1:0]  w_seq_nxt;
    logic [DW-1:0]     r_state_cnt;
    logic [DW-1:0]     w_state_cnt_nxt;
    logic              r_startup;
    logic              w_startup_nxt;

    logic              w_chg;
    logic              w_is_up;
    logic              w_is_ver;
    logic              w_is_state;
    logic              w_in_ch;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [DW-1:0]     w_cap_a;
    logic [DW-1:0]     w_cap_b;
    logic [UP_W-1:0]   w_sec;
    logic [UP_W-1:0]   w_tics;

    rpspmc_uptime_counter #(
        .CLK_HZ (CLK_HZ)
    ) u_uptime (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .clock_sec  (w_sec),
        .clock_tics (w_tics)
    );

    assign w_chg      = (config_addr != r_prev_addr);
    assign w_is_up    = (config_addr == ADDR_W'(ADDR_UPTIME));
    assign w_is_ver   = (config_addr == ADDR_W'(ADDR_VERSION));
    assign w_is_state = (config_addr == ADDR_W'(ADDR_STATE));
    assign w_off      = config_addr - ADDR_W'(BASE_ADDR);
    assign w_in_ch    = (config_addr >= ADDR_W'(BASE_ADDR)) && (w_off < ADDR_W'(N_CH));
    assign w_idx      = IDX_W'(w_off);

    // Snapshot source decode; special addresses win over the channel window.
    always_comb begin
        w_cap_a = '1;
        w_cap_b = DW'(config_addr);
        if (w_is_up) begin
            w_cap_a = DW'(w_sec);
            w_cap_b = DW'(w_tics);
        end else if (w_is_ver) begin
            w_cap_a = DW'(VERSION_A);
            w_cap_b = DW'(VERSION_B);
        end else if (w_is_state) begin
            w_cap_a = r_state_cnt;
            w_cap_b = DW'(r_startup);
        end else if (w_in_ch) begin
            w_cap_a = ch_a[w_idx*DW +: DW];
            w_cap_b = ch_b[w_idx*DW +: DW];
        end
    end

    // Next-state and registered-output logic; an address change overrides every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_data_a_nxt    = r_data_a;
        w_data_b_nxt    = r_data_b;
        w_valid_nxt     = r_valid;
        w_seq_nxt       = r_seq;
        w_state_cnt_nxt = r_state_cnt;
        w_startup_nxt   = r_startup;

        if (w_chg) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_nxt = ST_CAPTURE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    w_data_a_nxt = w_cap_a;
                    w_data_b_nxt = w_cap_b;
                    w_valid_nxt  = 1'b1;
                    w_seq_nxt    = r_seq + SEQ_W'(1);
                    w_state_nxt  = ST_HOLD;
                    if (w_is_state) begin
                        w_state_cnt_nxt = r_state_cnt + DW'(1);
                    end
                    if (w_is_ver) begin
                        w_startup_nxt = 1'b0;
                    end
                end
                ST_HOLD: begin
                    w_state_nxt = ST_HOLD;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_prev_addr <= '0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_valid     <= 1'b0;
            r_seq       <= '0;
            r_state_cnt <= '0;
            r_startup   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_prev_addr <= config_addr;
            r_data_a    <= w_data_a_nxt;
            r_data_b    <= w_data_b_nxt;
            r_valid     <= w_valid_nxt;
            r_seq       <= w_seq_nxt;
            r_state_cnt <= w_state_cnt_nxt;
            r_startup   <= w_startup_nxt;
        end
    end

    assign gpio_dataA = r_data_a;
    assign gpio_dataB = r_data_b;
    assign rb_valid   = r_valid;
    assign rb_seq     = r_seq;
    assign clock_sec  = w_sec;
    assign clock_tics = w_tics;

endmodule

// File: tb/tb_readback_snapshot_mux.sv
// Randomized bench for readback_snapshot_mux against a transaction-level model.
module tb_readback_snapshot_mux;
    localparam int unsigned N_CH = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned BASE = 100001;
    localparam int unsigned UP   = 101900;
    localparam int unsigned VER  = 199997;
    localparam int unsigned ST   = 199999;
    localparam int unsigned HZ   = 10;
    localparam int unsigned SC   = 2;
    localparam logic [31:0] VA   = 32'hEC010100;
    localparam logic [31:0] VB   = 32'h20250601;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [N_CH*DW-1:0] ch_a;
    logic [N_CH*DW-1:0] ch_b;

    readback_snapshot_mux_if #(.DW(DW)) rb_if ();

    readback_snapshot_mux #(
        .N_CH(N_CH), .DW(DW), .BASE_ADDR(BASE), .ADDR_UPTIME(UP),
        .ADDR_VERSION(VER), .ADDR_STATE(ST), .CLK_HZ(HZ), .SETTLE_CYC(SC),
        .VERSION_A(VA), .VERSION_B(VB)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .config_addr (rb_if.config_addr),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .gpio_dataA  (rb_if.gpio_dataA),
        .gpio_dataB  (rb_if.gpio_dataB),
        .rb_valid    (rb_if.rb_valid),
        .rb_seq      (rb_if.rb_seq),
        .clock_sec   (rb_if.clock_sec),
        .clock_tics  (rb_if.clock_tics)
    );

    always #5 aclk = ~aclk;

    // Elapsed edges since reset release, for the uptime expectation.
    int unsigned cyc;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_a [N_CH];
    logic [31:0] m_b [N_CH];
    int unsigned m_state_cnt;
    bit          m_startup;
    int unsigned m_seq;
    logic [31:0] last_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_channels(input bit rnd);
        for (int k = 0; k < N_CH; k++) begin
            if (rnd) begin
                m_a[k] = $urandom;
                m_b[k] = $urandom;
            end
            ch_a[k*DW +: DW] = m_a[k];
            ch_b[k*DW +: DW] = m_b[k];
        end
    endtask

    task automatic model_reset();
        m_state_cnt = 0;
        m_startup   = 1'b1;
        m_seq       = 0;
    endtask

    function automatic void model_capture(input logic [31:0] addr, input int unsigned up,
                                          output logic [31:0] ea, output logic [31:0] eb);
        if (addr == UP) begin
            ea = up / HZ;
            eb = (HZ - 1) - (up % HZ);
        end else if (addr == VER) begin
            ea = VA;
            eb = VB;
        end else if (addr == ST) begin
            ea = m_state_cnt;
            eb = {31'd0, m_startup};
        end else if (addr >= BASE && addr < BASE + N_CH) begin
            ea = m_a[addr - BASE];
            eb = m_b[addr - BASE];
        end else begin
            ea = 32'hFFFF_FFFF;
            eb = addr;
        end
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_A"},    64'(rb_if.gpio_dataA), 64'd0);
        check({tag, "_B"},    64'(rb_if.gpio_dataB), 64'd0);
        check({tag, "_vld"},  64'(rb_if.rb_valid),   64'd0);
        check({tag, "_seq"},  64'(rb_if.rb_seq),     64'd0);
        check({tag, "_sec"},  64'(rb_if.clock_sec),  64'd0);
        check({tag, "_tics"}, 64'(rb_if.clock_tics), 64'(HZ - 1));
    endtask

    // Apply an address and expect a capture exactly SC+2 edges later.
    task automatic select(input logic [31:0] addr, input string tag,
                          output logic [31:0] ea, output logic [31:0] eb);
        int lat;
        lat = 0;
        rb_if.config_addr = addr;
        for (int i = 1; i <= 20; i++) begin
            @(posedge aclk); #1;
            if (rb_if.rb_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(SC + 2));
        model_capture(addr, cyc - 1, ea, eb);
        if (addr == ST)  m_state_cnt++;
        if (addr == VER) m_startup = 1'b0;
        m_seq = (m_seq + 1) % 256;
        check({tag, "_A"},   64'(rb_if.gpio_dataA), 64'(ea));
        check({tag, "_B"},   64'(rb_if.gpio_dataB), 64'(eb));
        check({tag, "_seq"}, 64'(rb_if.rb_seq),     64'(m_seq));
        last_addr = addr;
    endtask

    task automatic hold_check(input logic [31:0] ea, input logic [31:0] eb);
        load_channels(1'b1);
        repeat (3) @(posedge aclk);
        #1;
        check("hold_vld", 64'(rb_if.rb_valid),   64'd1);
        check("hold_A",   64'(rb_if.gpio_dataA), 64'(ea));
        check("hold_B",   64'(rb_if.gpio_dataB), 64'(eb));
        check("hold_seq", 64'(rb_if.rb_seq),     64'(m_seq));
    endtask

    initial begin
        logic [31:0] ea, eb, addr;
        int unsigned cat;

        // Reset with channel 3 preset
        model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_a[k] = $urandom;
            m_b[k] = $urandom;
        end
        m_a[3] = 32'h11;
        m_b[3] = 32'h22;
        load_channels(1'b0);
        rb_if.config_addr = BASE + 3;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_values("rst");
        aresetn = 1'b1;
        select(BASE + 3, "ch3", ea, eb);
        check("ch3_lit_A", 64'(rb_if.gpio_dataA), 64'h11);
        check("ch3_lit_B", 64'(rb_if.gpio_dataB), 64'h22);

        // State counter / startup flag sequence
        select(ST, "st0", ea, eb);
        check("st0_lit", 64'(rb_if.gpio_dataA), 64'd0);
        select(BASE + 1, "lv1", ea, eb);
        select(ST, "st1", ea, eb);
        select(BASE + 2, "lv2", ea, eb);
        select(ST, "st2", ea, eb);
        check("st2_lit_A", 64'(rb_if.gpio_dataA), 64'd2);
        check("st2_lit_B", 64'(rb_if.gpio_dataB), 64'd1);
        select(VER, "ver", ea, eb);
        select(ST, "st3", ea, eb);
        check("st3_lit_A", 64'(rb_if.gpio_dataA), 64'd3);
        check("st3_lit_B", 64'(rb_if.gpio_dataB), 64'd0);

        // Uptime coherence
        repeat (25) @(posedge aclk);
        #1;
        check("up_live", 64'(rb_if.clock_sec * HZ + (HZ - 1 - rb_if.clock_tics)), 64'(cyc));
        select(UP, "up", ea, eb);
        hold_check(ea, eb);

        // Randomized selections
        for (int it = 0; it < 40; it++) begin
            load_channels(1'b1);
            cat = $urandom_range(0, 6);
            case (cat)
                0: addr = BASE + $urandom_range(0, N_CH - 1);
                1: addr = UP;
                2: addr = VER;
                3: addr = ST;
                4: addr = BASE + N_CH;
                5: addr = BASE - 1;
                default: addr = $urandom;
            endcase
            if (addr == last_addr) addr = addr ^ 32'h8000_0000;
            select(addr, "rnd", ea, eb);
            if (it % 2 == 0) hold_check(ea, eb);
        end

        // Address changing every cycle never captures
        for (int i = 0; i < 9; i++) begin
            rb_if.config_addr = 32'h5000_0000 + i;
            @(posedge aclk); #1;
            check("churn_vld", 64'(rb_if.rb_valid), 64'd0);
            check("churn_seq", 64'(rb_if.rb_seq),   64'(m_seq));
        end
        select(32'h5000_0009, "churn_end", ea, eb);

        // Out-of-range channel, then reset during SETTLE
        select(BASE + N_CH, "oor", ea, eb);
        check("oor_lit_A", 64'(rb_if.gpio_dataA), 64'hFFFF_FFFF);
        check("oor_lit_B", 64'(rb_if.gpio_dataB), 64'(BASE + N_CH));
        rb_if.config_addr = BASE + 5;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_values("inrst");
        aresetn = 1'b1;
        select(BASE + 5, "postrst", ea, eb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
